// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcodes, NOP encoding, instruction width and FSM states
//               for the ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int INSTR_W = 20;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_ADDA = 4'h4;
    localparam logic [3:0] OP_MAC  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NAND = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hA;
    localparam logic [3:0] OP_XNOR = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_EQU  = 4'hE;
    localparam logic [3:0] OP_LTH  = 4'hF;

    // ADDA 0,0 leaves the downstream accumulator untouched
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_ADDA, 8'h00, 8'h00};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic is_div_zero(input logic [INSTR_W-1:0] instr);
        return (instr[19:16] == OP_DIV) && (instr[7:0] == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Program-load, run-control and ALU-issue bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic [4:0]         prog_len;
    logic               start;
    logic               hold;
    logic [3:0]         opcode;
    logic [7:0]         A;
    logic [7:0]         B;
    logic               issue;
    logic               res_valid;
    logic               busy;
    logic               done;
    logic               div_zero;

    modport master (
        output wr_en, wr_addr, wr_data, prog_len, start, hold,
        input  opcode, A, B, issue, res_valid, busy, done, div_zero
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, prog_len, start, hold,
        output opcode, A, B, issue, res_valid, busy, done, div_zero
    );

endinterface
`default_nettype wire

// File: rtl/alu_seq_imem.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_imem
// Description : Instruction slot storage, one synchronous write port and one
//               asynchronous read port; intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_imem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic               clk,
    input  wire logic               i_we,
    input  wire logic [AW-1:0]      i_waddr,
    input  wire logic [INSTR_W-1:0] i_wdata,
    input  wire logic [AW-1:0]      i_raddr,
    output      logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues a stored program of ALU instructions, one per cycle,
//               with hold, drain/done signalling and sticky divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input wire logic          clk,
    input wire logic          rst,
    alu_op_sequencer_if.slave bus
);

    localparam int         c_AW    = $clog2(DEPTH);
    localparam logic [4:0] c_DEPTH = 5'(DEPTH);

    state_t             r_state;
    logic [4:0]         r_pc;
    logic [4:0]         r_len;
    logic [3:0]         r_opcode;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic               r_issue;
    logic               r_res_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic [c_AW-1:0]    w_rd_addr;
    logic [INSTR_W-1:0] w_instr;
    logic [4:0]         w_len;
    logic               w_wr_en;

    // Slot 0 must be readable in IDLE so a start can issue it immediately
    assign w_rd_addr = (r_state == ST_IDLE) ? '0 : r_pc[c_AW-1:0];
    assign w_len     = (bus.prog_len > c_DEPTH) ? c_DEPTH : bus.prog_len;
    assign w_wr_en   = bus.wr_en && (r_state == ST_IDLE) && !bus.start &&
                       ({1'b0, bus.wr_addr} < c_DEPTH);

    alu_seq_imem #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (bus.wr_addr[c_AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= ST_IDLE;
            r_pc                  <= 5'd0;
            r_len                 <= 5'd0;
            {r_opcode, r_a, r_b}  <= NOP_INSTR;
            r_issue               <= 1'b0;
            r_res_valid           <= 1'b0;
            r_busy                <= 1'b0;
            r_done                <= 1'b0;
            r_div_zero            <= 1'b0;
        end else begin
            r_res_valid           <= r_issue;
            {r_opcode, r_a, r_b}  <= NOP_INSTR;
            r_issue               <= 1'b0;
            r_done                <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_len  <= w_len;
                        r_busy <= 1'b1;
                        if (w_len != 5'd0) begin
                            {r_opcode, r_a, r_b} <= w_instr;
                            r_issue              <= 1'b1;
                            r_div_zero           <= is_div_zero(w_instr);
                            r_pc                 <= 5'd1;
                            r_state              <= ST_RUN;
                        end else begin
                            r_div_zero <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.hold) begin
                        if (r_pc < r_len) begin
                            {r_opcode, r_a, r_b} <= w_instr;
                            r_issue              <= 1'b1;
                            r_pc                 <= r_pc + 5'd1;
                            if (is_div_zero(w_instr)) begin
                                r_div_zero <= 1'b1;
                            end
                        end else begin
                            // done lands together with the last res_valid
                            r_done  <= 1'b1;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_pc    <= 5'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_pc    <= 5'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.opcode    = r_opcode;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.issue     = r_issue;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench: program-level reference model plus a
//               small behavioural ALU for end-to-end result checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compares = 0;
    int fails    = 0;

    logic [19:0] mem_model [DEPTH];
    logic [15:0] exp_alu_q [$];
    logic [15:0] alu_out = 16'h0000;

    // Downstream ALU: every opcode writes its accumulator/result register
    always @(posedge clk) begin
        case (bus.opcode)
            OP_ADD:  alu_out <= {8'h00, bus.A} + {8'h00, bus.B};
            OP_SUB:  alu_out <= {8'h00, bus.A} - {8'h00, bus.B};
            OP_MUL:  alu_out <= {8'h00, bus.A} * {8'h00, bus.B};
            OP_DIV:  alu_out <= (bus.B == 8'h00) ? 16'hFFFF : {8'h00, bus.A / bus.B};
            OP_ADDA: alu_out <= alu_out + {8'h00, bus.A} + {8'h00, bus.B};
            OP_MAC:  alu_out <= alu_out + {8'h00, bus.A} * {8'h00, bus.B};
            default: alu_out <= {8'h00, bus.A ^ bus.B};
        endcase
    end

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [19:0] rnd_instr();
        logic [3:0] op;
        logic [7:0] b;
        op = ($urandom_range(0, 3) == 0) ? OP_DIV : 4'($urandom_range(0, 15));
        b  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        return {op, 8'($urandom), b};
    endfunction

    function automatic logic [24:0] pk(input bit iss, input logic [19:0] ins, input bit rv,
                                       input bit bsy, input bit dn, input bit dz);
        return {iss, ins, rv, bsy, dn, dz};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] exp);
        logic [24:0] act;
        act = {bus.issue, bus.opcode, bus.A, bus.B, bus.res_valid, bus.busy, bus.done,
               bus.div_zero};
        compares++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (iss,op,A,B,rv,busy,done,dz)", tag, act, exp);
        end
    endtask

    task automatic chk_alu(input string tag, input logic [15:0] exp);
        compares++;
        assert (alu_out === exp) else begin
            fails++;
            $error("FAIL %s alu: observed %0d expected %0d", tag, alu_out, exp);
        end
    endtask

    task automatic write_slot(input logic [3:0] addr, input logic [19:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
        if (int'(addr) < DEPTH) mem_model[addr] = data;
    endtask

    // Program-level model: slots issue in order, a held cycle becomes a NOP,
    // and the cycle after the last slot is the done cycle.
    task automatic run_prog(input string tag, input logic [4:0] plen, input int hold_pct,
                            input logic [31:0] hold_mask, input bit noise);
        int lc, n, cyc;
        bit dz, prev_iss, fin, h;
        logic [19:0] ins;
        lc = (int'(plen) > DEPTH) ? DEPTH : int'(plen);
        bus.start    = 1'b1;
        bus.prog_len = plen;
        bus.hold     = 1'($urandom_range(0, 1));
        if (noise) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'd0;
            bus.wr_data = 20'($urandom);
        end
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        cyc = 1;
        n   = 0;
        if (lc == 0) begin
            dz = 1'b0; fin = 1'b1; prev_iss = 1'b0;
            chk($sformatf("%s c1", tag), pk(1'b0, NOP_INSTR, 1'b0, 1'b1, 1'b1, 1'b0));
        end else begin
            ins = mem_model[0];
            dz  = is_div_zero(ins); fin = 1'b0; n = 1; prev_iss = 1'b1;
            chk($sformatf("%s c1", tag), pk(1'b1, ins, 1'b0, 1'b1, 1'b0, dz));
        end
        while (!fin && cyc < 100) begin
            bit rv;
            h = (cyc < 32 && hold_mask[cyc]) || ($urandom_range(0, 99) < hold_pct);
            bus.hold = h;
            if (noise) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.prog_len = 5'($urandom);
                bus.wr_en    = 1'b1;
                bus.wr_addr  = 4'($urandom_range(0, 15));
                bus.wr_data  = 20'($urandom);
            end
            step();
            cyc++;
            rv = prev_iss;
            if (h) begin
                chk($sformatf("%s c%0d", tag, cyc), pk(1'b0, NOP_INSTR, rv, 1'b1, 1'b0, dz));
                prev_iss = 1'b0;
            end else if (n < lc) begin
                ins = mem_model[n];
                n++;
                dz = dz | is_div_zero(ins);
                chk($sformatf("%s c%0d", tag, cyc), pk(1'b1, ins, rv, 1'b1, 1'b0, dz));
                prev_iss = 1'b1;
            end else begin
                chk($sformatf("%s c%0d", tag, cyc), pk(1'b0, NOP_INSTR, rv, 1'b1, 1'b1, dz));
                prev_iss = 1'b0;
                fin = 1'b1;
            end
            if (rv && exp_alu_q.size() > 0) chk_alu($sformatf("%s c%0d", tag, cyc), exp_alu_q.pop_front());
        end
        compares++;
        assert (fin) else begin
            fails++;
            $error("FAIL %s timeout: observed running expected done", tag);
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.hold  = 1'($urandom_range(0, 1));
        step();
        chk($sformatf("%s idle", tag), pk(1'b0, NOP_INSTR, 1'b0, 1'b0, 1'b0, dz));
        bus.hold = 1'b0;
    endtask

    initial begin
        bit dz;
        bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 20'd0;
        bus.prog_len = 5'd0; bus.start = 1'b1; bus.hold = 1'b0;
        rst = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        chk("reset", pk(1'b0, NOP_INSTR, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_slot(4'(i), rnd_instr());

        // Basic three-slot program with ALU results 7, 7, 30
        write_slot(4'd0, mk(OP_ADD, 8'd3, 8'd4));
        write_slot(4'd1, mk(OP_SUB, 8'd9, 8'd2));
        write_slot(4'd2, mk(OP_MUL, 8'd5, 8'd6));
        exp_alu_q = {16'd7, 16'd7, 16'd30};
        run_prog("prog3", 5'd3, 0, 32'h0, 1'b0);

        // Hold for two cycles after first issue; accumulator ends at 23
        write_slot(4'd0, mk(OP_ADD, 8'd2, 8'd3));
        write_slot(4'd1, mk(OP_ADDA, 8'd10, 8'd0));
        write_slot(4'd2, mk(OP_MAC, 8'd2, 8'd4));
        exp_alu_q = {16'd5, 16'd15, 16'd23};
        run_prog("hold2", 5'd3, 0, 32'h6, 1'b0);

        // Sticky divide-by-zero, cleared only by the next accepted start
        write_slot(4'd0, mk(OP_DIV, 8'd8, 8'd0));
        run_prog("div0", 5'd1, 0, 32'h0, 1'b0);
        step();
        chk("div0 sticky", pk(1'b0, NOP_INSTR, 1'b0, 1'b0, 1'b0, 1'b1));
        run_prog("len0", 5'd0, 0, 32'h0, 1'b0);

        // Clamp and out-of-range writes
        for (int i = 0; i < DEPTH; i++) write_slot(4'(i), rnd_instr());
        run_prog("clamp", 5'd20, 0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) write_slot(4'($urandom_range(DEPTH, 15)), rnd_instr());
        run_prog("oor", 5'd8, 0, 32'h0, 1'b0);

        // Reset in the middle of a run, then rerun from untouched storage
        for (int i = 0; i < 5; i++) write_slot(4'(i), rnd_instr());
        bus.start = 1'b1; bus.prog_len = 5'd5; bus.hold = 1'b0;
        step();
        bus.start = 1'b0;
        dz = is_div_zero(mem_model[0]);
        chk("midrst s0", pk(1'b1, mem_model[0], 1'b0, 1'b1, 1'b0, dz));
        step();
        dz = dz | is_div_zero(mem_model[1]);
        chk("midrst s1", pk(1'b1, mem_model[1], 1'b1, 1'b1, 1'b0, dz));
        step();
        dz = dz | is_div_zero(mem_model[2]);
        chk("midrst s2", pk(1'b1, mem_model[2], 1'b1, 1'b1, 1'b0, dz));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst rst", pk(1'b0, NOP_INSTR, 1'b0, 1'b0, 1'b0, 1'b0));
        run_prog("midrst rerun", 5'd5, 0, 32'h0, 1'b0);

        // Writes and starts while busy are ignored; rerun reproduces the program
        run_prog("noise", 5'd5, 20, 32'h0, 1'b1);
        run_prog("noise rerun", 5'd5, 0, 32'h0, 1'b0);

        // Randomised programs
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 3; k++) write_slot(4'($urandom_range(0, 15)), rnd_instr());
            run_prog($sformatf("rnd%0d", r), 5'($urandom_range(0, 12)), 30, 32'h0,
                     1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001: Parameter DEPTH, default 16, number of instruction slots (power of two, 2..16).
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: wr_en  input  1  instruction-slot write strobe.
REQ-005: wr_addr  input  4  slot index to write.
REQ-006: wr_data  input  20  instruction {opcode[19:16], A[15:8], B[7:0]}.
REQ-007: prog_len  input  5  number of slots to run, sampled at start.
REQ-008: start  input  1  run request, sampled in IDLE only.
REQ-009: hold  input  1  pause issue while high.
REQ-010: opcode  output  4  registered opcode to downstream ALU.
REQ-011: A  output  8  registered operand A to ALU.
REQ-012: B  output  8  registered operand B to ALU.
REQ-013: issue  output  1  high when opcode/A/B carry a program instruction.
REQ-014: res_valid  output  1  issue delayed one cycle; ALU result valid this cycle.
REQ-015: busy  output  1  high in RUN and DRAIN.
REQ-016: done  output  1  one-cycle pulse when final result is on ALU output.
REQ-017: div_zero  output  1  sticky: a DIV (4'b0011) with B==0 was issued this run.

Function
REQ-018: FSM states SHALL be IDLE, RUN, DRAIN.
REQ-019: Whenever issue is low, outputs SHALL drive NOP = ADDA with A=0, B=0 (opcode 4'b0100), preserving downstream accumulator.
REQ-020: IDLE + start with prog_len>0: load slot 0 onto outputs, issue=1, pc=1, clear div_zero, go RUN.
REQ-021: IDLE + start with prog_len==0: no issue, clear div_zero, go DRAIN.
REQ-022: prog_len > DEPTH SHALL be clamped to DEPTH.
REQ-023: RUN, hold=0, pc<len: load slot pc, issue=1, pc+1.
REQ-024: RUN, hold=0, pc==len: drive NOP, issue=0, go DRAIN.
REQ-025: RUN, hold=1: drive NOP, issue=0, pc unchanged, remain RUN.
REQ-026: DRAIN: done=1 for exactly one cycle, then IDLE; hold ignored in DRAIN.
REQ-027: start→done latency SHALL be prog_len+1 cycles plus held cycles; done coincides with final res_valid.
REQ-028: wr_en SHALL write slot wr_addr only in IDLE without start that cycle; otherwise ignored; wr_addr >= DEPTH ignored.
REQ-029: start while busy SHALL be ignored.
REQ-030: div_zero SHALL set on the cycle a DIV with B==0 is issued and hold until next accepted start or rst.

Reset
REQ-031: rst SHALL force IDLE, pc=0, NOP outputs, issue=0, res_valid=0, busy=0, done=0, div_zero=0 next cycle, including mid-RUN/DRAIN.
REQ-032: Slot storage SHALL NOT be reset; contents survive rst.

Structure
REQ-033: Shared package alu_seq_pkg SHALL hold opcode constants (ADD..LTH), NOP encoding, instruction width 20, state enum.
REQ-034: Slot storage SHALL be sub-module alu_seq_imem (one sync write port, one async read port).

Verification
REQ-035: Load slots {ADD 3,4; SUB 9,2; MUL 5,6}, prog_len=3, start -> issue high 3 cycles, res_valid cycles show ALU_Out 7, 7, 30; done on 4th cycle after start.
REQ-036: Slots {ADD 2,3; ADDA 10; MAC 2,4}, prog_len=3, hold high 2 cycles after first issue -> NOP during hold, final ALU_Out 23, done at cycle 6.
REQ-037: Slot {DIV 8,0}, prog_len=1 -> div_zero=1 after issue, stays 1 until next start.
REQ-038: prog_len=0 start -> no issue, done one cycle later, busy high one cycle.
REQ-039: rst mid-RUN at slot 2 of 5 -> next cycle IDLE, NOP outputs, busy=0; restart runs all 5 slots from unchanged storage.
REQ-040: wr_en during RUN to slot 0 and start during busy -> both ignored; rerun reproduces original results.
